// File: rtl/cluster_cg_pkg.sv
// Shared types for the cluster clock-gate controller: FSM state encoding and stats width.
// The gated-cycle statistics counter is built only when CLUSTER_CG_STATS_EN is defined.
package cluster_cg_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2,
        WAKE      = 2'd3
    } cg_state_e;

    localparam int unsigned STATS_WIDTH = 32;

    // True when the power manager may proceed toward gating this cycle.
    function automatic logic sleep_qualified(input logic sleep_req,
                                             input logic busy,
                                             input logic wake,
                                             input logic test_en);
        return sleep_req & ~busy & ~wake & ~test_en;
    endfunction

endpackage

// File: rtl/cluster_cg_assert.sv
// Simulation checks on the clock-gate controller outputs and parameters.
module cluster_cg_assert #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input logic clk_i,
    input logic rst_i,
    input logic clk_en_i,
    input logic sleep_ack_i
);

    a_params: assert property (@(posedge clk_i)
        (IDLE_CYCLES >= 32'sd1) && (WAKE_CYCLES >= 32'sd1));

    a_en_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(clk_en_i));

    // Acknowledging sleep while the clock still runs would let the PM cut power under a live cluster.
    a_ack_gated: assert property (@(posedge clk_i) disable iff (rst_i)
        sleep_ack_i |-> !clk_en_i);

endmodule

// File: rtl/cluster_cg_counter.sv
// Saturating up-counter shared by the idle-hysteresis and wake-settle phases.
// Stops at the terminal value supplied by the caller; clear wins over enable.
module cluster_cg_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] term_i,
    output logic                 at_term_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign at_term_o = (cnt_q == term_i);

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (en_i && !at_term_o) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock-gate enable controller: sleep handshake, idle hysteresis, wake settle.
// Optional gated-cycle statistics counter enabled by defining CLUSTER_CG_STATS_EN.
module cluster_clock_gate_ctrl
    import cluster_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef CLUSTER_CG_STATS_EN
    input  logic        stats_clr_i,
    output logic [31:0] gated_cycles_o,
`endif
    input  logic        busy_i,
    input  logic        sleep_req_i,
    input  logic        wake_i,
    input  logic        test_en_i,
    output logic        clk_en_o,
    output logic        test_en_o,
    output logic        sleep_ack_o,
    output logic        ready_o
);

    localparam logic [CNT_WIDTH-1:0] IDLE_TERM = CNT_WIDTH'(IDLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAKE_TERM = CNT_WIDTH'(WAKE_CYCLES - 1);

    cg_state_e            state_q;
    cg_state_e            state_d;
    logic                 clk_en_q;
    logic                 sleep_ack_q;
    logic                 ready_q;
    logic                 qual_s;
    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 at_term_s;
    logic [CNT_WIDTH-1:0] cnt_term_s;

    assign qual_s     = sleep_qualified(sleep_req_i, busy_i, wake_i, test_en_i);
    assign cnt_clr_s  = (state_q == RUN) || (state_q == GATED);
    assign cnt_en_s   = (state_q == IDLE_WAIT) || (state_q == WAKE);
    assign cnt_term_s = (state_q == WAKE) ? WAKE_TERM : IDLE_TERM;

    cluster_cg_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (cnt_clr_s),
        .en_i      (cnt_en_s),
        .term_i    (cnt_term_s),
        .at_term_o (at_term_s)
    );

    // Next-state logic; any wake/busy/test/withdrawn request beats the sleep request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (qual_s) state_d = IDLE_WAIT;
                else        state_d = RUN;
            end
            IDLE_WAIT: begin
                if (!qual_s)        state_d = RUN;
                else if (at_term_s) state_d = GATED;
                else                state_d = IDLE_WAIT;
            end
            GATED: begin
                if (!qual_s) state_d = WAKE;
                else         state_d = GATED;
            end
            WAKE: begin
                if (at_term_s) state_d = RUN;
                else           state_d = WAKE;
            end
            default: state_d = RUN;
        endcase
    end

    // State and outputs registered together so they change on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            clk_en_q    <= 1'b1;
            sleep_ack_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= (state_d != GATED);
            sleep_ack_q <= (state_d == GATED);
            ready_q     <= (state_d == RUN) || (state_d == IDLE_WAIT);
        end
    end

    assign clk_en_o    = clk_en_q;
    assign sleep_ack_o = sleep_ack_q;
    assign ready_o     = ready_q;
    assign test_en_o   = test_en_i;

`ifdef CLUSTER_CG_STATS_EN
    logic [STATS_WIDTH-1:0] gated_cycles_q;

    // Gated-cycle counter; clk_i is the ungated clock so it keeps counting while gated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gated_cycles_q <= {STATS_WIDTH{1'b0}};
        end else if (stats_clr_i) begin
            gated_cycles_q <= {STATS_WIDTH{1'b0}};
        end else if ((state_q == GATED) && (gated_cycles_q != {STATS_WIDTH{1'b1}})) begin
            gated_cycles_q <= gated_cycles_q + STATS_WIDTH'(1);
        end else begin
            gated_cycles_q <= gated_cycles_q;
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`endif

    cluster_cg_assert #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) u_assert (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clk_en_i    (clk_en_q),
        .sleep_ack_i (sleep_ack_q)
    );

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Self-checking bench for cluster_clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Reference model counts consecutive qualifying edges and remaining settle edges.
module tb_cluster_clock_gate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        busy_i = 1'b0;
    logic        sleep_req_i = 1'b0;
    logic        wake_i = 1'b0;
    logic        test_en_i = 1'b0;
    logic        stats_clr = 1'b0;
    logic        clk_en_o;
    logic        test_en_o;
    logic        sleep_ack_o;
    logic        ready_o;
`ifdef CLUSTER_CG_STATS_EN
    logic [31:0] gated_cycles_o;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_gated;
    bit          m_waking;
    int          m_run_len;
    int          m_wake_left;
    longint      m_stats;

    cluster_clock_gate_ctrl #(
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .CNT_WIDTH   (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
`ifdef CLUSTER_CG_STATS_EN
        .stats_clr_i    (stats_clr),
        .gated_cycles_o (gated_cycles_o),
`endif
        .busy_i      (busy_i),
        .sleep_req_i (sleep_req_i),
        .wake_i      (wake_i),
        .test_en_i   (test_en_i),
        .clk_en_o    (clk_en_o),
        .test_en_o   (test_en_o),
        .sleep_ack_o (sleep_ack_o),
        .ready_o     (ready_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_reset();
        m_gated     = 1'b0;
        m_waking    = 1'b0;
        m_run_len   = 0;
        m_wake_left = 0;
        m_stats     = 0;
    endfunction

    function automatic void model_edge(bit b, bit s, bit w, bit t, bit c);
        bit q;
        q = s && !b && !w && !t;
        if (c) m_stats = 0;
        else if (m_gated && m_stats < 64'hFFFF_FFFF) m_stats = m_stats + 1;
        if (m_gated) begin
            if (!q) begin
                m_gated     = 1'b0;
                m_waking    = 1'b1;
                m_wake_left = WAKE;
            end
        end else if (m_waking) begin
            m_wake_left = m_wake_left - 1;
            if (m_wake_left == 0) m_waking = 1'b0;
            m_run_len = 0;
        end else begin
            m_run_len = q ? m_run_len + 1 : 0;
            if (m_run_len == IDLE + 1) begin
                m_gated   = 1'b1;
                m_run_len = 0;
            end
        end
    endfunction

    task automatic step(bit b, bit s, bit w, bit t, bit c);
        busy_i      = b;
        sleep_req_i = s;
        wake_i      = w;
        test_en_i   = t;
        stats_clr   = c;
        @(posedge clk_i);
        model_edge(b, s, w, t, c);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        busy_i      = 1'b0;
        sleep_req_i = 1'b0;
        wake_i      = 1'b0;
        test_en_i   = 1'b0;
        stats_clr   = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({clk_en_o, sleep_ack_o, ready_o, test_en_o} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_state en/ack/ready/ten=%b expected 1010",
                     {clk_en_o, sleep_ack_o, ready_o, test_en_o});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({clk_en_o, sleep_ack_o, ready_o} !== 3'b101) begin
            bad++;
            $display("FAIL reset_idle en/ack/ready=%b expected 101",
                     {clk_en_o, sleep_ack_o, ready_o});
        end
    endtask

    task automatic test_gate_wake();
        logic [2:0] exp;
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            step(1'b0, 1'b1, (e == 11), 1'b0, 1'b0);
            exp[2] = !(e >= 5 && e <= 10);
            exp[1] = (e >= 5 && e <= 10);
            exp[0] = (e < 5) || (e >= 13);
            total++;
            if ({clk_en_o, sleep_ack_o, ready_o} !== exp) begin
                bad++;
                $display("FAIL gate_wake edge %0d en/ack/ready=%b expected %b",
                         e, {clk_en_o, sleep_ack_o, ready_o}, exp);
            end
        end
    endtask

    task automatic test_busy_abort();
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            step((e == 4), 1'b1, 1'b0, 1'b0, 1'b0);
            total++;
            if (clk_en_o !== (e < 9)) begin
                bad++;
                $display("FAIL busy_abort edge %0d clk_en=%b expected %b", e, clk_en_o, (e < 9));
            end
        end
    endtask

    task automatic test_wake_priority();
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            total++;
            if ({clk_en_o, sleep_ack_o, ready_o} !== 3'b101) begin
                bad++;
                $display("FAIL wake_priority edge %0d en/ack/ready=%b expected 101",
                         e, {clk_en_o, sleep_ack_o, ready_o});
            end
        end
    endtask

    task automatic test_test_en_and_async_reset();
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            total++;
            if ({clk_en_o, test_en_o} !== 2'b11) begin
                bad++;
                $display("FAIL test_en edge %0d en/ten=%b expected 11", e, {clk_en_o, test_en_o});
            end
        end
        for (int e = 1; e <= 6; e++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({clk_en_o, sleep_ack_o, ready_o, test_en_o} !== 4'b0100) begin
            bad++;
            $display("FAIL gated_before_rst en/ack/ready/ten=%b expected 0100",
                     {clk_en_o, sleep_ack_o, ready_o, test_en_o});
        end
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if ({clk_en_o, sleep_ack_o, ready_o} !== 3'b101) begin
            bad++;
            $display("FAIL async_reset en/ack/ready=%b expected 101",
                     {clk_en_o, sleep_ack_o, ready_o});
        end
        do_reset();
    endtask

    task automatic test_random();
        bit b, s, w, t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 9) < 8);
            b = ($urandom_range(0, 19) == 0);
            w = ($urandom_range(0, 29) == 0);
            t = ($urandom_range(0, 49) == 0);
            step(b, s, w, t, 1'b0);
            total++;
            if ({clk_en_o, sleep_ack_o, ready_o, test_en_o} !==
                {!m_gated, m_gated, !m_gated && !m_waking, t}) begin
                bad++;
                $display("FAIL random step %0d en/ack/ready/ten=%b expected %b", i,
                         {clk_en_o, sleep_ack_o, ready_o, test_en_o},
                         {!m_gated, m_gated, !m_gated && !m_waking, t});
            end
        end
    endtask

`ifdef CLUSTER_CG_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int e = 1; e <= 5 + 20; e++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (gated_cycles_o !== 32'd20 || longint'(gated_cycles_o) != m_stats) begin
            bad++;
            $display("FAIL stats_count got %0d expected 20", gated_cycles_o);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (gated_cycles_o !== 32'd0) begin
            bad++;
            $display("FAIL stats_clear got %0d expected 0", gated_cycles_o);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (gated_cycles_o !== 32'd1) begin
            bad++;
            $display("FAIL stats_after_clear got %0d expected 1", gated_cycles_o);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_gate_wake();
        test_busy_abort();
        test_wake_priority();
        test_test_en_and_async_reset();
        test_random();
`ifdef CLUSTER_CG_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
